// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word-addressed requests to instruction memory,
// presents fetched instructions to IF/ID, and handles stalls and branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hazard_Detected,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            PC_out,
  output logic [31:0]            Instruction_out,
  output logic                   if_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;

  logic        ready;
  logic        bus_pending;
  logic [31:0] addr_inc;

  assign ready       = imem.imem_ready;
  assign addr_inc    = addr_q + 32'd1;
  // A request is outstanding and not yet answered: a branch must drain it first.
  assign bus_pending = ((state_q == FETCH) || (state_q == DRAIN)) && !ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          state_d = ready ? FETCH : DRAIN;
        end else if (ready && hazard_Detected) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken || !hazard_Detected) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    imem.imem_req   = req_q;
    imem.imem_addr  = addr_q;
    PC_out          = pc_out_q;
    Instruction_out = instr_q;
    if_valid        = valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= (state_d == FETCH) || (state_d == DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      pc_out_q    <= 32'd0;
      instr_q     <= 32'd0;
      valid_q     <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over a stall; the presented slot becomes a bubble.
      instr_q     <= 32'd0;
      valid_q     <= 1'b0;
      pc_q        <= branch_target;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      if (!bus_pending) begin
        addr_q <= branch_target;
      end
    end else begin
      case (state_q)
        IDLE: begin
          addr_q <= pc_q;
        end
        FETCH: begin
          if (ready) begin
            pc_q <= addr_inc;
            if (!hazard_Detected) begin
              instr_q  <= imem.imem_rdata;
              pc_out_q <= addr_inc;
              valid_q  <= 1'b1;
              addr_q   <= addr_inc;
            end else begin
              buf_instr_q <= imem.imem_rdata;
              buf_pc_q    <= addr_inc;
            end
          end else if (!hazard_Detected) begin
            instr_q <= 32'd0;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!hazard_Detected) begin
            instr_q  <= buf_instr_q;
            pc_out_q <= buf_pc_q;
            valid_q  <= 1'b1;
            addr_q   <= pc_q;
          end
        end
        DRAIN: begin
          if (ready) begin
            addr_q <= pc_q;
          end
        end
        default: begin
          addr_q <= pc_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for if_fetch_unit against a transaction-level
// reference model of the fetch rules.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_Detected;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic        if_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5C30F17 ^ {a[15:0], a[31:16]};
  endfunction

  if_fetch_unit_if bus();

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  if_fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_Detected (hazard_Detected),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem            (bus),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .if_valid        (if_valid)
  );

  // Reference model: tracks the bus transaction, any parked (stalled) response,
  // and whether the outstanding response must be thrown away.
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_next_pc;
  logic        m_stale;
  logic        m_parked;
  logic [31:0] m_park_instr;
  logic [31:0] m_park_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_instr;
  logic        m_valid;

  task automatic modelReset();
    m_req        = 1'b0;
    m_addr       = 32'd0;
    m_next_pc    = 32'd0;
    m_stale      = 1'b0;
    m_parked     = 1'b0;
    m_park_instr = 32'd0;
    m_park_pc    = 32'd0;
    m_pc_out     = 32'd0;
    m_instr      = 32'd0;
    m_valid      = 1'b0;
  endtask

  task automatic modelEdge();
    logic        got;
    logic [31:0] nxt;
    got = m_req && bus.imem_ready;
    nxt = m_addr + 32'd1;
    if (branch_taken) begin
      m_instr   = 32'd0;
      m_valid   = 1'b0;
      m_parked  = 1'b0;
      m_next_pc = branch_target;
      if (m_req && !bus.imem_ready) begin
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
        m_req   = 1'b1;
        m_addr  = branch_target;
      end
    end else if (m_stale) begin
      if (got) begin
        m_stale = 1'b0;
        m_addr  = m_next_pc;
      end
    end else if (!m_req) begin
      if (!m_parked) begin
        m_req  = 1'b1;
        m_addr = m_next_pc;
      end else if (!hazard_Detected) begin
        m_instr  = m_park_instr;
        m_pc_out = m_park_pc;
        m_valid  = 1'b1;
        m_parked = 1'b0;
        m_req    = 1'b1;
        m_addr   = m_next_pc;
      end
    end else if (got) begin
      m_next_pc = nxt;
      if (!hazard_Detected) begin
        m_instr  = mem_word(m_addr);
        m_pc_out = nxt;
        m_valid  = 1'b1;
        m_addr   = nxt;
      end else begin
        m_park_instr = mem_word(m_addr);
        m_park_pc    = nxt;
        m_parked     = 1'b1;
        m_req        = 1'b0;
      end
    end else if (!hazard_Detected) begin
      m_instr = 32'd0;
      m_valid = 1'b0;
    end
  endtask

  task automatic expectValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic checkOutput(input string phase);
    total++;
    assert (if_valid === m_valid) else begin
      bad++;
      $error("[TB] FAIL %s if_valid got=%b want=%b", phase, if_valid, m_valid);
    end
    total++;
    assert (Instruction_out === m_instr) else begin
      bad++;
      $error("[TB] FAIL %s Instruction_out got=%h want=%h", phase, Instruction_out, m_instr);
    end
    total++;
    assert (PC_out === m_pc_out) else begin
      bad++;
      $error("[TB] FAIL %s PC_out got=%h want=%h", phase, PC_out, m_pc_out);
    end
    total++;
    assert (bus.imem_req === m_req) else begin
      bad++;
      $error("[TB] FAIL %s imem_req got=%b want=%b", phase, bus.imem_req, m_req);
    end
    if (m_req) begin
      total++;
      assert (bus.imem_addr === m_addr) else begin
        bad++;
        $error("[TB] FAIL %s imem_addr got=%h want=%h", phase, bus.imem_addr, m_addr);
      end
    end
  endtask

  task automatic applyStimulus(input logic hz, input logic br, input logic [31:0] tgt,
                               input logic rdy, input string phase);
    hazard_Detected = hz;
    branch_taken    = br;
    branch_target   = tgt;
    bus.imem_ready  = rdy;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(phase);
  endtask

  task automatic randomRun(input int cycles);
    logic [31:0] tgt;
    for (int i = 0; i < cycles; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, tgt,
                    $urandom_range(0, 9) < 6, "random");
    end
  endtask

  initial begin
    rst             = 1'b0;
    hazard_Detected = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'd0;
    bus.imem_ready  = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_hold");
    #6;
    rst = 1'b1;

    // First edge after release leaves IDLE and raises the request.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, "boot");
    expectValue("boot_req", 32'(bus.imem_req), 32'd1);
    expectValue("boot_addr", bus.imem_addr, 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "zero_wait");
      expectValue("zw_instr", Instruction_out, mem_word(32'(i)));
      expectValue("zw_pc", PC_out, 32'(i + 1));
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "zero_wait");

    // mem[4] returns under a three-cycle stall; ready while idle is ignored.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "stall_capture");
    expectValue("stall_frozen_pc", PC_out, 32'd4);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "stall_hold");
      expectValue("stall_req_low", 32'(bus.imem_req), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, "stall_release");
    expectValue("release_instr", Instruction_out, mem_word(32'd4));
    expectValue("release_pc", PC_out, 32'd5);

    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, "branch_over_hazard");
    expectValue("bh_valid", 32'(if_valid), 32'd0);
    expectValue("bh_addr", bus.imem_addr, 32'h40);

    // Branch away from a pending fetch of 7 that still needs two wait cycles.
    applyStimulus(1'b0, 1'b1, 32'd7, 1'b1, "goto7");
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, "drain_branch");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, "drain_wait");
      expectValue("drain_addr", bus.imem_addr, 32'd7);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "drain_done");
    expectValue("drain_new_addr", bus.imem_addr, 32'h80);
    expectValue("drain_no_instr", 32'(if_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "after_drain");
    expectValue("after_drain_instr", Instruction_out, mem_word(32'h80));

    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, "wrap_branch");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "wrap_fetch");
    expectValue("wrap_pc", PC_out, 32'd0);
    expectValue("wrap_instr", Instruction_out, mem_word(32'hFFFFFFFF));
    expectValue("wrap_next_addr", bus.imem_addr, 32'd0);

    randomRun(600);

    // Reset lands mid-fetch while memory answers in the same cycle.
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, "pre_reset");
    hazard_Detected = 1'b0;
    branch_taken    = 1'b0;
    bus.imem_ready  = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    expectValue("async_reset_instr", Instruction_out, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge");
    #2;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "restart");
    expectValue("restart_addr", bus.imem_addr, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "restart_fetch");
    expectValue("restart_instr", Instruction_out, mem_word(32'd0));

    randomRun(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
